// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types, segment table and width helper for the 7-segment scan driver
package seven_seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns for a common-anode digit, indexed by nibble value
   localparam seg_t SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Bits needed to hold 0..n-1, never less than one bit
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hex_to_seg_ca.sv
// rtl/hex_to_seg_ca.sv - combinational hex nibble to active-low common-anode segment decoder
module hex_to_seg_ca
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg_n
);

   assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - tearing-free multiplexed N-digit 7-segment driver; optional LEADING_ZERO_BLANK_EN
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   output logic                    pending,
   output logic                    frame_start,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n
);

   localparam int CNT_W = width_of(REFRESH_DIV);
   localparam int IDX_W = width_of(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;
   logic                    tick;
   logic                    commit;

   logic [4*NUM_DIGITS-1:0] sh_data;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic [NUM_DIGITS-1:0]   sh_blank;
   logic [4*NUM_DIGITS-1:0] disp_data;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic [NUM_DIGITS-1:0]   disp_blank;

   logic [4*NUM_DIGITS-1:0] src_data;
   logic [NUM_DIGITS-1:0]   src_dp;
   logic [NUM_DIGITS-1:0]   src_blank;
   logic [NUM_DIGITS-1:0]   src_eff_blank;

   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   seg_t                    cur_seg;
   logic [NUM_DIGITS-1:0]   an_next;

   assign tick   = (cnt == CNT_LAST);
   assign commit = tick && (idx == IDX_LAST);

   // A load coinciding with the commit edge bypasses the shadow straight into the display
   always_comb begin
      src_data  = load ? data_in  : sh_data;
      src_dp    = load ? dp_in    : sh_dp;
      src_blank = load ? blank_in : sh_blank;
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  zero_above;

   always_comb begin
      lz_mask    = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (src_data[4*i +: 4] != 4'h0) begin
            zero_above = 1'b0;
         end
         lz_mask[i] = zero_above;
      end
   end

   assign src_eff_blank = src_blank | lz_mask;
`else
   assign src_eff_blank = src_blank;
`endif

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib   = disp_data[4*i +: 4];
            cur_dp    = disp_dp[i];
            cur_blank = disp_blank[i];
         end
      end
   end

   hex_to_seg_ca u_dec (
      .nibble (cur_nib),
      .seg_n  (cur_seg)
   );

   // Anodes stay dark for the first BLANK_CYCLES of every slot to hide ghosting
   always_comb begin
      an_next = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((idx == IDX_W'(i)) && (cnt >= BLANK_START) && !disp_blank[i]) begin
            an_next[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt         <= '0;
         idx         <= '0;
         sh_data     <= '0;
         sh_dp       <= '0;
         sh_blank    <= '0;
         disp_data   <= '0;
         disp_dp     <= '0;
         disp_blank  <= '0;
         pending     <= 1'b0;
         frame_start <= 1'b0;
         seg_n       <= SEG_BLANK;
         dp_n        <= 1'b1;
         an_n        <= '1;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end

         frame_start <= commit;

         if (commit) begin
            if (load || pending) begin
               disp_data  <= src_data;
               disp_dp    <= src_dp;
               disp_blank <= src_eff_blank;
            end
            pending <= 1'b0;
         end else if (load) begin
            sh_data  <= data_in;
            sh_dp    <= dp_in;
            sh_blank <= blank_in;
            pending  <= 1'b1;
         end

         seg_n <= cur_blank ? SEG_BLANK : cur_seg;
         dp_n  <= cur_blank | ~cur_dp;
         an_n  <= an_next;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - randomized self-checking bench with a frame-level reference model
module tb_seven_seg_scan_driver;

   localparam int N = 4;
   localparam int R = 8;
   localparam int B = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load;
   logic [15:0]   data_in;
   logic [3:0]    dp_in;
   logic [3:0]    blank_in;
   logic          pending;
   logic          frame_start;
   logic [6:0]    seg_n;
   logic          dp_n;
   logic [3:0]    an_n;

   always #5 clk = ~clk;

   seven_seg_scan_driver #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (R),
      .BLANK_CYCLES (B)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .data_in     (data_in),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
      .pending     (pending),
      .frame_start (frame_start),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .an_n        (an_n)
   );

   logic [6:0] seg_ref [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   int checks = 0;
   int errors = 0;

   // Model: n counts clock edges since reset; slot and position follow from plain division
   int          n;
   logic [15:0] m_sh_data, m_d_data;
   logic [3:0]  m_sh_dp, m_sh_blank, m_d_dp, m_d_blank;
   logic        m_pending;
   logic [6:0]  exp_seg;
   logic [3:0]  exp_an;
   logic        exp_dp;
   logic        exp_fs;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] eff_blank(input logic [15:0] d, input logic [3:0] bl);
      logic [3:0] mask;
      mask = 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
      begin
         int top;
         top = 0;
         for (int i = 0; i < N; i++) if (d[4*i +: 4] != 4'h0) top = i;
         for (int i = 0; i < N; i++) if (i > top) mask[i] = 1'b1;
      end
`endif
      return bl | mask;
   endfunction

   function automatic bit commit_next();
      return ((n % R) == R - 1) && (((n / R) % N) == N - 1);
   endfunction

   task automatic model_edge();
      int pos;
      int d;
      bit cm;
      if (!rst_n) begin
         n = 0;
         m_sh_data = '0; m_sh_dp = '0; m_sh_blank = '0;
         m_d_data = '0;  m_d_dp = '0;  m_d_blank = '0;
         m_pending = 1'b0;
         exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1; exp_fs = 1'b0;
      end else begin
         pos = n % R;
         d   = (n / R) % N;
         cm  = (pos == R - 1) && (d == N - 1);
         exp_an = 4'hF;
         if (pos >= B && !m_d_blank[d]) exp_an[d] = 1'b0;
         exp_seg = m_d_blank[d] ? 7'h7F : seg_ref[m_d_data[4*d +: 4]];
         exp_dp  = m_d_blank[d] | ~m_d_dp[d];
         exp_fs  = cm;
         if (cm) begin
            if (load) begin
               m_d_data = data_in; m_d_dp = dp_in; m_d_blank = eff_blank(data_in, blank_in);
            end else if (m_pending) begin
               m_d_data = m_sh_data; m_d_dp = m_sh_dp; m_d_blank = eff_blank(m_sh_data, m_sh_blank);
            end
            m_pending = 1'b0;
         end else if (load) begin
            m_sh_data = data_in; m_sh_dp = dp_in; m_sh_blank = blank_in;
            m_pending = 1'b1;
         end
         n++;
      end
   endtask

   task automatic step(input logic r, input logic l, input logic [15:0] d,
                       input logic [3:0] dp, input logic [3:0] bl);
      rst_n = r; load = l; data_in = d; dp_in = dp; blank_in = bl;
      @(posedge clk);
      model_edge();
      #1;
      check("seg_n", 32'(seg_n), 32'(exp_seg));
      check("an_n", 32'(an_n), 32'(exp_an));
      check("dp_n", 32'(dp_n), 32'(exp_dp));
      check("pending", 32'(pending), 32'(m_pending));
      check("frame_start", 32'(frame_start), 32'(exp_fs));
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++)
         step(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
   endtask

   task automatic to_commit();
      int guard;
      guard = 0;
      while (!commit_next() && guard < 64) begin
         idle(1);
         guard++;
      end
      check("commit_reached", 32'(commit_next()), 32'd1);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; blank_in = '0;
      n = 0; m_pending = 1'b0;

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
      check("reset_seg", 32'(seg_n), 32'h7F);
      check("reset_an", 32'(an_n), 32'hF);

      // First commit lands 32 edges after release
      step(1'b1, 1'b1, 16'h1234, 4'h0, 4'h0);
      lat = 1;
      while (frame_start !== 1'b1 && lat < 100) begin
         idle(1);
         lat++;
      end
      check("first_commit_latency", 32'(lat), 32'd32);
      idle(N * R);

      // Mid-frame load held in the shadow until commit
      idle(R + 3);
      step(1'b1, 1'b1, 16'hABCD, 4'h0, 4'h0);
      check("dbuf_pending", 32'(pending), 32'd1);
      idle(2 * N * R);

      // Load on the commit edge bypasses the shadow
      to_commit();
      step(1'b1, 1'b1, 16'h00F0, 4'h0, 4'h0);
      check("collision_pending", 32'(pending), 32'd0);
      idle(N * R);

      step(1'b1, 1'b1, 16'h5A3C, 4'b0001, 4'b0100);
      idle(2 * N * R);
      step(1'b1, 1'b1, 16'h0005, 4'h0, 4'h0);
      idle(2 * N * R);
      step(1'b1, 1'b1, 16'h0000, 4'h0, 4'h0);
      idle(2 * N * R);

      // Reset mid-load discards the shadow
      idle(5);
      step(1'b1, 1'b1, 16'h9876, 4'hF, 4'h0);
      step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
      check("reset_discard_pending", 32'(pending), 32'd0);
      idle(2 * N * R);

      for (int i = 0; i < 1500; i++) begin
         if (($urandom % 8) == 0 || (commit_next() && ($urandom % 2) == 0))
            step(1'b1, 1'b1, 16'($urandom), 4'($urandom), 4'($urandom % 4 == 0 ? $urandom : 0));
         else if ($urandom % 700 == 0)
            step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
         else
            idle(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
